// File: rtl/fir_ntap_seq_if.sv
// Sample/result handshake and coefficient-load bus for fir_ntap_seq.
// master drives samples and coefficients; slave is the filter.
interface fir_ntap_seq_if #(
  parameter int DATAWIDTH = 16,
  parameter int COEFWIDTH = 16,
  parameter int NTAPS     = 8
);
  localparam int ACCWIDTH = DATAWIDTH + COEFWIDTH + $clog2(NTAPS);
  localparam int AW       = $clog2(NTAPS);

  logic                        coef_we;
  logic [AW-1:0]               coef_addr;
  logic signed [COEFWIDTH-1:0] coef_data;

  logic                        x_valid;
  logic                        x_ready;
  logic signed [DATAWIDTH-1:0] x;

  logic                        y_valid;
  logic                        y_ready;
  logic signed [ACCWIDTH-1:0]  y;

  modport master (
    output coef_we, coef_addr, coef_data, x_valid, x, y_ready,
    input  x_ready, y_valid, y
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, x_valid, x, y_ready,
    output x_ready, y_valid, y
  );
endinterface

// File: rtl/fir_ntap_seq.sv
// N-tap signed FIR filter with loadable coefficients and one shared MAC,
// computing one product per cycle between the sample and result handshakes.
module fir_ntap_seq #(
  parameter int DATAWIDTH = 16,
  parameter int COEFWIDTH = 16,
  parameter int NTAPS     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  output logic         busy,
  output logic         done,
  fir_ntap_seq_if.slave bus
);
  localparam int ACCWIDTH = DATAWIDTH + COEFWIDTH + $clog2(NTAPS);
  localparam int PW       = DATAWIDTH + COEFWIDTH;
  localparam int AW       = $clog2(NTAPS);

  typedef enum logic [1:0] {IDLE, RUN, MAC, OUT} state_t;

  state_t                      state_q, state_d;
  logic signed [DATAWIDTH-1:0] d_q [NTAPS];
  logic signed [COEFWIDTH-1:0] c_q [NTAPS];
  logic signed [ACCWIDTH-1:0]  acc_q, acc_d;
  logic signed [ACCWIDTH-1:0]  y_q, y_d;
  logic signed [ACCWIDTH-1:0]  sum;
  logic signed [PW-1:0]        prod;
  logic [AW-1:0]               k_q, k_d;
  logic                        y_valid_q, y_valid_d;
  logic                        stop_pend_q, stop_pend_d;
  logic                        done_q, done_d;
  logic                        shift_en, clear_en, coef_en, last_tap, x_ready_c;
  logic [NTAPS-1:0]            coef_hit;

  assign prod     = c_q[k_q] * d_q[k_q];
  assign sum      = acc_q + {{(ACCWIDTH-PW){prod[PW-1]}}, prod};
  assign last_tap = (k_q == AW'(NTAPS - 1));
  assign clear_en = (state_q == IDLE) && clear;
  assign coef_en  = (state_q == IDLE) && bus.coef_we;

  // Addresses >= NTAPS match no tap and are dropped by the decode itself.
  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_coef_dec
    assign coef_hit[gi] = coef_en && (bus.coef_addr == AW'(gi));
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    y_d         = y_q;
    y_valid_d   = y_valid_q;
    k_d         = k_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    shift_en    = 1'b0;
    x_ready_c   = 1'b0;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) state_d = RUN;
      end
      RUN: begin
        x_ready_c = !stop && !stop_pend_q;
        if (stop || stop_pend_q) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end else if (bus.x_valid) begin
          shift_en = 1'b1;
          acc_d    = '0;
          k_d      = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        if (stop) stop_pend_d = 1'b1;
        acc_d = sum;
        k_d   = k_q + 1'b1;
        if (last_tap) begin
          y_d       = sum;
          y_valid_d = 1'b1;
          k_d       = '0;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (stop) stop_pend_d = 1'b1;
        if (bus.y_ready) begin
          y_valid_d = 1'b0;
          if (stop || stop_pend_q) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      k_q         <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      y_valid_q   <= y_valid_d;
      k_q         <= k_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  // Delay line survives stop/start; only reset or an IDLE clear empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        d_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      if (clear_en) begin
        for (int i = 0; i < NTAPS; i++) d_q[i] <= '0;
      end else if (shift_en) begin
        d_q[0] <= bus.x;
        for (int i = 1; i < NTAPS; i++) d_q[i] <= d_q[i-1];
      end
      for (int i = 0; i < NTAPS; i++) begin
        if (coef_hit[i]) c_q[i] <= bus.coef_data;
      end
    end
  end

  assign bus.x_ready = x_ready_c;
  assign bus.y_valid = y_valid_q;
  assign bus.y       = y_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
endmodule

// File: tb/tb_fir_ntap_seq.sv
// Randomised self-checking bench for fir_ntap_seq (NTAPS=4) against a
// sample-history reference model.
module tb_fir_ntap_seq;
  localparam int DW = 16, CW = 16, NT = 4, AW = 2, ACCW = 34;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic busy, done;

  fir_ntap_seq_if #(.DATAWIDTH(DW), .COEFWIDTH(CW), .NTAPS(NT)) bus ();

  fir_ntap_seq #(.DATAWIDTH(DW), .COEFWIDTH(CW), .NTAPS(NT)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .busy(busy), .done(done), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  longint c_m [NT];
  longint hist[$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic longint model_y();
    longint s = 0;
    for (int k = 0; k < NT; k++) s += c_m[k] * hist[k];
    return s;
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int k = 0; k < NT; k++) hist.push_back(0);
  endtask

  task automatic write_coef(input int k, input longint v, input bit in_idle);
    bus.coef_we = 1'b1; bus.coef_addr = AW'(k); bus.coef_data = CW'(v);
    step();
    bus.coef_we = 1'b0;
    if (in_idle) c_m[k] = v;
  endtask

  task automatic clear_line();
    clear = 1'b1; step(); clear = 1'b0;
    model_clear();
  endtask

  task automatic go_run();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send(input logic signed [DW-1:0] xv, input int hold,
                      output longint yv, output int lat, output bit to);
    int n = 0;
    to = 1'b0; yv = 0; lat = 0;
    while (bus.x_ready !== 1'b1 && n < 50) begin step(); n++; end
    if (bus.x_ready !== 1'b1) begin to = 1'b1; return; end
    bus.x_valid = 1'b1; bus.x = xv;
    step();
    bus.x_valid = 1'b0;
    hist.push_front(longint'(xv));
    void'(hist.pop_back());
    while (bus.y_valid !== 1'b1 && lat < 50) begin step(); lat++; end
    if (bus.y_valid !== 1'b1) begin to = 1'b1; return; end
    repeat (hold) step();
    yv = bus.y;
    bus.y_ready = 1'b1; step(); bus.y_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (bus.x_ready !== 1'b0) begin errors++; $display("FAIL reset_x_ready got=%b exp=0", bus.x_ready); end
    checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got=%b exp=0", bus.y_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (bus.y !== '0) begin errors++; $display("FAIL reset_y got=%0d exp=0", bus.y); end
    rst = 1'b1;
    step();
    $display("reset released");
  endtask

  task automatic test_impulse();
    longint yv, exp_tbl [5];
    int lat; bit to;
    logic signed [DW-1:0] xs [5];
    exp_tbl = '{1, 2, 3, 4, 0};
    xs = '{16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    clear_line();
    for (int k = 0; k < NT; k++) write_coef(k, k + 1, 1'b1);
    go_run();
    for (int i = 0; i < 5; i++) begin
      send(xs[i], 0, yv, lat, to);
      $display("impulse x=%0d y=%0d", xs[i], yv);
      checks++; if (to) begin errors++; $display("FAIL impulse_timeout i=%0d got=timeout exp=result", i); end
      checks++; if (yv !== exp_tbl[i] || yv !== model_y()) begin errors++; $display("FAIL impulse_y i=%0d got=%0d exp=%0d", i, yv, exp_tbl[i]); end
      checks++; if (bus.x_ready !== 1'b1) begin errors++; $display("FAIL impulse_x_ready_after_hs got=%b exp=1", bus.x_ready); end
      if (i == 0) begin
        checks++; if (lat != NT) begin errors++; $display("FAIL impulse_latency got=%0d exp=%0d", lat, NT); end
      end
    end
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL impulse_stop got=done%b busy%b exp=done1 busy0", done, busy); end
  endtask

  task automatic test_extreme();
    longint yv, exp_tbl [4];
    int lat; bit to;
    exp_tbl = '{64'sd1 <<< 30, 64'sd1 <<< 31, 64'sd3 <<< 30, 64'sd1 <<< 32};
    clear_line();
    for (int k = 0; k < NT; k++) write_coef(k, -32768, 1'b1);
    go_run();
    for (int i = 0; i < 4; i++) begin
      send(-16'sd32768, 0, yv, lat, to);
      $display("extreme n=%0d y=%0d", i, yv);
      checks++; if (to || yv !== exp_tbl[i]) begin errors++; $display("FAIL extreme_y n=%0d got=%0d exp=%0d", i, yv, exp_tbl[i]); end
    end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_timing();
    longint y0, expv;
    int n = 0;
    for (int k = 0; k < NT; k++) write_coef(k, $urandom_range(0, 65535) - 32768, 1'b1);
    go_run();
    bus.x_valid = 1'b1; bus.x = DW'($urandom);
    step();
    bus.x_valid = 1'b0;
    hist.push_front(longint'(bus.x)); void'(hist.pop_back());
    expv = model_y();
    while (bus.y_valid !== 1'b1 && n < 50) begin step(); n++; end
    checks++; if (n != NT) begin errors++; $display("FAIL timing_latency got=%0d exp=%0d", n, NT); end
    y0 = bus.y;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.y !== ACCW'(y0) || bus.y_valid !== 1'b1 || bus.x_ready !== 1'b0) begin
        errors++; $display("FAIL timing_hold c=%0d got=y%0d v%b xr%b exp=y%0d v1 xr0", i, bus.y, bus.y_valid, bus.x_ready, y0);
      end
    end
    checks++; if (y0 !== expv) begin errors++; $display("FAIL timing_y got=%0d exp=%0d", y0, expv); end
    bus.y_ready = 1'b1; step(); bus.y_ready = 1'b0;
    $display("timing y=%0d held 5 cycles", y0);
    checks++; if (bus.x_ready !== 1'b1 || bus.y_valid !== 1'b0) begin errors++; $display("FAIL timing_after_hs got=xr%b v%b exp=xr1 v0", bus.x_ready, bus.y_valid); end
  endtask

  task automatic test_stop_mac();
    longint expv;
    int n = 0;
    write_coef(0, 12345, 1'b0);
    bus.x_valid = 1'b1; bus.x = DW'($urandom);
    step();
    bus.x_valid = 1'b0;
    hist.push_front(longint'(bus.x)); void'(hist.pop_back());
    expv = model_y();
    step();
    stop = 1'b1; step(); stop = 1'b0;
    while (bus.y_valid !== 1'b1 && n < 50) begin
      checks++; if (bus.x_ready !== 1'b0) begin errors++; $display("FAIL stopmac_x_ready got=%b exp=0", bus.x_ready); end
      step(); n++;
    end
    $display("stop_mac y=%0d", bus.y);
    checks++; if (bus.y_valid !== 1'b1 || bus.y !== ACCW'(expv)) begin errors++; $display("FAIL stopmac_y got=%0d exp=%0d", bus.y, expv); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL stopmac_busy got=busy%b done%b exp=busy1 done0", busy, done); end
    bus.y_ready = 1'b1; step(); bus.y_ready = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || bus.x_ready !== 1'b0) begin errors++; $display("FAIL stopmac_done got=done%b busy%b xr%b exp=done1 busy0 xr0", done, busy, bus.x_ready); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stopmac_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_stop_xvalid();
    longint yv;
    int lat; bit to;
    go_run();
    bus.x_valid = 1'b1; bus.x = 16'sd7777; stop = 1'b1;
    #1;
    checks++; if (bus.x_ready !== 1'b0) begin errors++; $display("FAIL stopx_x_ready got=%b exp=0", bus.x_ready); end
    step();
    bus.x_valid = 1'b0; stop = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stopx_done got=done%b busy%b exp=done1 busy0", done, busy); end
    go_run();
    send(DW'($urandom), 0, yv, lat, to);
    $display("stop_xvalid restart y=%0d", yv);
    checks++; if (to || yv !== model_y()) begin errors++; $display("FAIL stopx_retained got=%0d exp=%0d", yv, model_y()); end
  endtask

  task automatic test_random();
    longint yv;
    int lat; bit to;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        stop = 1'b1; step(); stop = 1'b0;
        write_coef($urandom_range(0, NT-1), $urandom_range(0, 65535) - 32768, 1'b1);
        go_run();
      end
      send(DW'($urandom), $urandom_range(0, 3), yv, lat, to);
      $display("random n=%0d y=%0d", i, yv);
      checks++; if (to || yv !== model_y()) begin errors++; $display("FAIL random_y n=%0d got=%0d exp=%0d", i, yv, model_y()); end
    end
  endtask

  task automatic test_async_reset();
    longint yv;
    int lat; bit to;
    bus.x_valid = 1'b1; bus.x = DW'($urandom);
    step();
    bus.x_valid = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.y_valid !== 1'b0 || bus.x_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.y !== '0) begin
      errors++; $display("FAIL async_reset got=v%b xr%b busy%b done%b y%0d exp=all0", bus.y_valid, bus.x_ready, busy, done, bus.y);
    end
    step(); step();
    rst = 1'b1;
    for (int k = 0; k < NT; k++) c_m[k] = 0;
    model_clear();
    step();
    go_run();
    for (int i = 0; i < 3; i++) begin
      send(DW'($urandom), 0, yv, lat, to);
      $display("after reset n=%0d y=%0d", i, yv);
      checks++; if (to || yv !== 0) begin errors++; $display("FAIL async_zero_y n=%0d got=%0d exp=0", i, yv); end
    end
  endtask

  initial begin
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    bus.x_valid = 1'b0; bus.x = '0; bus.y_ready = 1'b0;
    for (int k = 0; k < NT; k++) c_m[k] = 0;
    model_clear();
    test_reset();
    test_impulse();
    test_extreme();
    test_timing();
    test_stop_mac();
    test_stop_xvalid();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
